// File: rtl/window_pkg.sv
// Shared types and helpers for the window prefetcher.
package window_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DONE,
    FLUSH
  } fetch_state_t;

  // Value shown on pixel_out when no pixel is available.
  localparam int unsigned UNDERRUN_FILL = 0;

  // Number of pixels covered by a window with exclusive end bounds.
  function automatic int unsigned win_pixels(input int unsigned xs, input int unsigned xe,
                                             input int unsigned ys, input int unsigned ye);
    return (xe - xs) * (ye - ys);
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// First-word-fall-through pixel FIFO with occupancy count and synchronous flush.
module pixel_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic                              push,
  input  logic [DATA_WIDTH-1:0]             din,
  input  logic                              pop,
  output logic [DATA_WIDTH-1:0]             dout,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
  output logic                              empty
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_q;
  logic [PW-1:0]         rd_q;

  // Storage array; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_q] <= din;
    end
  end

  // Pointers and occupancy; flush discards everything held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      count <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      count <= '0;
    end else begin
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Head of queue is visible without a read cycle.
  always_comb begin
    dout  = mem_q[rd_q];
    empty = (count == '0);
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && !flush && (count == CW'(FIFO_DEPTH))));

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && empty && !flush));

endmodule

// File: rtl/window_fetch.sv
// Per-window pixel prefetcher: sequences framebuffer reads and feeds one pixel per in-window raster cycle.
module window_fetch
  import window_pkg::*;
#(
  parameter int unsigned SCREEN_WIDTH  = 640,
  parameter int unsigned SCREEN_HEIGHT = 480,
  parameter int unsigned X_START       = 0,
  parameter int unsigned X_END         = 64,
  parameter int unsigned Y_START       = 0,
  parameter int unsigned Y_END         = 64,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned FIFO_DEPTH    = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [$clog2(SCREEN_WIDTH)-1:0]  x,
  input  logic [$clog2(SCREEN_HEIGHT)-1:0] y,
  input  logic                             frame_start,
  input  logic [ADDR_WIDTH-1:0]            base_addr,
  output logic                             mem_req,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  input  logic                             mem_gnt,
  input  logic                             mem_rvalid,
  input  logic [DATA_WIDTH-1:0]            mem_rdata,
  output logic [DATA_WIDTH-1:0]            pixel_out,
  output logic                             pixel_valid,
  output logic                             underrun
);

  localparam int unsigned XW = $clog2(SCREEN_WIDTH);
  localparam int unsigned YW = $clog2(SCREEN_HEIGHT);
  localparam int unsigned N  = win_pixels(X_START, X_END, Y_START, Y_END);
  localparam int unsigned IW = $clog2(N + 1);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [IW-1:0]         index_q, index_d;
  logic [CW-1:0]         outs_q, outs_d;

  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;

  logic in_win;
  logic pop_req;
  logic pop;
  logic push;
  logic gnt_acc;
  logic credit;

  // Window membership: subtracting the start folds the lower bound into the unsigned wrap.
  always_comb begin
    in_win = (((XW+1)'(x) - (XW+1)'(X_START)) < (XW+1)'(X_END - X_START)) &&
             (((YW+1)'(y) - (YW+1)'(Y_START)) < (YW+1)'(Y_END - Y_START));
    pop_req = in_win && !frame_start;
    pop     = pop_req && !fifo_empty;
    push    = mem_rvalid && (state_q != FLUSH) && !frame_start;
  end

  // Head pixel is shown only when the raster is inside and data is present.
  always_comb begin
    pixel_valid = in_win && !fifo_empty;
    pixel_out   = pixel_valid ? fifo_head : DATA_WIDTH'(UNDERRUN_FILL);
    mem_addr    = base_q + ADDR_WIDTH'(index_q);
  end

  // Next-state and request logic; frame_start overrides whatever the current state wanted.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    mem_req = 1'b0;
    credit  = (({1'b0, fifo_count} + {1'b0, outs_q}) < (CW+1)'(FIFO_DEPTH));

    if (state_q == FETCH) begin
      mem_req = credit;
    end

    gnt_acc = mem_req && mem_gnt;
    outs_d  = outs_q + CW'(gnt_acc) - CW'(mem_rvalid);

    case (state_q)
      FETCH: begin
        if (gnt_acc) begin
          index_d = index_q + IW'(1);
          if (index_q == IW'(N - 1)) state_d = DONE;
        end
      end
      FLUSH: begin
        if (outs_d == '0) state_d = FETCH;
      end
      default: begin
      end
    endcase

    if (frame_start) begin
      index_d = '0;
      state_d = (outs_d == '0) ? FETCH : FLUSH;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Fetch index, in-flight count, latched base and sticky underrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q   <= '0;
      index_q  <= '0;
      outs_q   <= '0;
      underrun <= 1'b0;
    end else begin
      index_q <= index_d;
      outs_q  <= outs_d;
      if (frame_start) base_q <= base_addr;
      if (frame_start)                 underrun <= 1'b0;
      else if (pop_req && fifo_empty)  underrun <= 1'b1;
    end
  end

  pixel_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (frame_start),
    .push  (push),
    .din   (mem_rdata),
    .pop   (pop),
    .dout  (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_window_fetch.sv
// Directed bench for window_fetch with a queue-based reference model and arbiter/memory stand-in.
module tb_window_fetch;

  localparam int N     = 8;
  localparam int DEPTH = 4;
  localparam int OUTX  = 100;
  localparam int OUTY  = 100;

  logic        clk;
  logic        rst_n;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        frame_start;
  logic [15:0] base_addr;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [7:0]  mem_rdata;
  logic [7:0]  pixel_out;
  logic        pixel_valid;
  logic        underrun;

  window_fetch #(
    .SCREEN_WIDTH (640), .SCREEN_HEIGHT (480),
    .X_START (2), .X_END (6), .Y_START (1), .Y_END (3),
    .DATA_WIDTH (8), .ADDR_WIDTH (16), .FIFO_DEPTH (4)
  ) dut (
    .clk (clk), .rst_n (rst_n), .x (x), .y (y),
    .frame_start (frame_start), .base_addr (base_addr),
    .mem_req (mem_req), .mem_addr (mem_addr), .mem_gnt (mem_gnt),
    .mem_rvalid (mem_rvalid), .mem_rdata (mem_rdata),
    .pixel_out (pixel_out), .pixel_valid (pixel_valid), .underrun (underrun)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int checks;
  int errors;
  int cyc;
  int lat;
  bit dmode;
  bit resp_en;

  // Reference model state
  bit          m_active;
  bit          m_flush;
  int          m_idx;
  int          m_outs;
  bit          m_und;
  logic [15:0] m_base;
  logic [7:0]  mq[$];

  // Memory responses pending, in grant order
  int          rq_due[$];
  logic [7:0]  rq_dat[$];

  // Observations of the DUT for literal checks
  logic [15:0] alog[$];
  int          req_cycles;
  logic        last_req;
  logic [15:0] last_addr;
  logic [7:0]  last_pix;
  logic        last_valid;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] rdata_of(input logic [15:0] a);
    if (dmode) return a[7:0] ^ {a[11:8], 4'h0};
    return a[7:0];
  endfunction

  task automatic model_reset();
    m_active = 0; m_flush = 0; m_idx = 0; m_outs = 0; m_und = 0; m_base = 16'h0;
    mq.delete(); rq_due.delete(); rq_dat.delete(); alog.delete();
    req_cycles = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; frame_start = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = 8'h00; x = 10'(OUTX); y = 9'(OUTY);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One raster cycle: drive inputs, compare every output with the model, advance the model.
  task automatic cycle(input bit fs, input logic [15:0] base, input int cx, input int cy, input bit gnt);
    int sz; bit ereq; logic [15:0] eaddr; bit inwin; bit evalid; logic [7:0] epix; bit dopush;
    @(negedge clk);
    cyc++;
    frame_start = fs; base_addr = base; x = 10'(cx); y = 9'(cy); mem_gnt = gnt;
    mem_rvalid = 1'b0; mem_rdata = 8'h00;
    if (resp_en && rq_due.size() > 0 && rq_due[0] <= cyc) begin
      mem_rvalid = 1'b1; mem_rdata = rq_dat[0];
      rq_due.delete(0); rq_dat.delete(0);
    end
    #1;
    sz     = mq.size();
    ereq   = m_active && !m_flush && (m_idx < N) && (sz + m_outs < DEPTH);
    eaddr  = m_base + 16'(m_idx);
    inwin  = (cx >= 2) && (cx < 6) && (cy >= 1) && (cy < 3);
    evalid = inwin && (sz > 0);
    epix   = evalid ? mq[0] : 8'h00;
    chk("mem_req", 32'(mem_req), 32'(ereq));
    chk("mem_addr", 32'(mem_addr), 32'(eaddr));
    chk("pixel_valid", 32'(pixel_valid), 32'(evalid));
    chk("pixel_out", 32'(pixel_out), 32'(epix));
    chk("underrun", 32'(underrun), 32'(m_und));
    last_req = mem_req; last_addr = mem_addr; last_pix = pixel_out; last_valid = pixel_valid;
    if (mem_req) req_cycles++;
    if (mem_req && mem_gnt) alog.push_back(mem_addr);

    dopush = 0;
    if (ereq && gnt) begin
      rq_due.push_back(cyc + lat); rq_dat.push_back(rdata_of(eaddr));
      m_idx++; m_outs++;
    end
    if (mem_rvalid) begin
      m_outs--;
      dopush = !m_flush && !fs;
    end
    if (inwin && !fs) begin
      if (sz > 0) mq.delete(0);
      else        m_und = 1;
    end
    if (dopush) mq.push_back(mem_rdata);
    if (m_flush && m_outs == 0) m_flush = 0;
    if (fs) begin
      m_base = base; m_idx = 0; m_und = 0; mq.delete();
      m_active = 1; m_flush = (m_outs != 0);
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; lat = 2; dmode = 0; resp_en = 1;
    rst_n = 1'b0; frame_start = 1'b0; base_addr = 16'h0; x = 10'(OUTX); y = 9'(OUTY);
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 8'h00;
    model_reset();
    #1;
    // 1. Reset
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_valid", 32'(pixel_valid), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    do_reset();
    repeat (100) cycle(0, 16'h0, OUTX, OUTY, 1);
    chk("rst_idle_req_cycles", 32'(req_cycles), 32'd0);

    // 2. Nominal frame
    do_reset();
    cycle(1, 16'h0100, OUTX, OUTY, 1);
    repeat (20) cycle(0, 16'h0, OUTX, OUTY, 1);
    chk("nom_prefetch_cnt", 32'(alog.size()), 32'd4);
    for (int i = 0; i < 4 && i < alog.size(); i++)
      chk("nom_prefetch_addr", 32'(alog[i]), 32'h100 + 32'(i));
    for (int row = 1; row < 3; row++) begin
      for (int xx = 2; xx < 6; xx++) begin
        cycle(0, 16'h0, xx, row, 1);
        chk("nom_pix", 32'(last_pix), 32'((row - 1) * 4 + xx - 2));
        chk("nom_pix_valid", 32'(last_valid), 32'd1);
      end
      repeat (10) cycle(0, 16'h0, OUTX, OUTY, 1);
    end
    chk("nom_total_grants", 32'(alog.size()), 32'd8);
    if (alog.size() > 0) chk("nom_last_addr", 32'(alog[alog.size() - 1]), 32'h107);
    chk("nom_underrun", 32'(underrun), 32'd0);

    // 3. Backpressure
    do_reset();
    cycle(1, 16'h0100, OUTX, OUTY, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 16'h0, OUTX, OUTY, 0);
      chk("bp_req_held", 32'(last_req), 32'd1);
      chk("bp_addr_held", 32'(last_addr), 32'h100);
    end
    cycle(0, 16'h0, OUTX, OUTY, 1);
    cycle(0, 16'h0, OUTX, OUTY, 0);
    chk("bp_addr_after_gnt", 32'(last_addr), 32'h101);

    // 4. Underrun: memory never answers
    do_reset();
    resp_en = 0;
    cycle(1, 16'h0100, OUTX, OUTY, 1);
    repeat (8) cycle(0, 16'h0, OUTX, OUTY, 1);
    cycle(0, 16'h0, 2, 1, 1);
    chk("ur_pix", 32'(last_pix), 32'd0);
    chk("ur_valid", 32'(last_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 16'h0, OUTX, OUTY, 1);
      chk("ur_sticky", 32'(underrun), 32'd1);
    end
    cycle(1, 16'h0200, OUTX, OUTY, 1);
    chk("ur_held_on_fs", 32'(underrun), 32'd1);
    cycle(0, 16'h0, OUTX, OUTY, 0);
    chk("ur_cleared", 32'(underrun), 32'd0);
    resp_en = 1;

    // 5. Abort with reads in flight
    do_reset();
    lat = 3; dmode = 1;
    cycle(1, 16'h0100, OUTX, OUTY, 1);
    repeat (3) cycle(0, 16'h0, OUTX, OUTY, 1);
    cycle(1, 16'h0200, OUTX, OUTY, 0);
    cycle(0, 16'h0, OUTX, OUTY, 0);
    chk("ab_flush_req0", 32'(last_req), 32'd0);
    cycle(0, 16'h0, OUTX, OUTY, 0);
    chk("ab_flush_req1", 32'(last_req), 32'd0);
    cycle(0, 16'h0, OUTX, OUTY, 1);
    chk("ab_refetch_req", 32'(last_req), 32'd1);
    chk("ab_refetch_addr", 32'(last_addr), 32'h200);
    repeat (10) cycle(0, 16'h0, OUTX, OUTY, 1);
    cycle(0, 16'h0, 2, 1, 1);
    chk("ab_first_pix", 32'(last_pix), 32'h20);
    chk("ab_first_valid", 32'(last_valid), 32'd1);

    // 5b. Restart with a full FIFO discards the old frame's pixels
    do_reset();
    lat = 2;
    cycle(1, 16'h0300, OUTX, OUTY, 1);
    repeat (10) cycle(0, 16'h0, OUTX, OUTY, 1);
    cycle(1, 16'h0400, OUTX, OUTY, 1);
    repeat (10) cycle(0, 16'h0, OUTX, OUTY, 1);
    cycle(0, 16'h0, 2, 1, 1);
    chk("rf_first_pix", 32'(last_pix), 32'h40);

    // 6. Asynchronous reset mid-fetch with three pixels buffered
    do_reset();
    dmode = 0;
    cycle(1, 16'h0100, OUTX, OUTY, 1);
    repeat (3) cycle(0, 16'h0, OUTX, OUTY, 1);
    repeat (4) cycle(0, 16'h0, OUTX, OUTY, 0);
    #2;
    x = 10'd2; y = 9'd1;
    #1;
    chk("ar_pre_valid", 32'(pixel_valid), 32'd1);
    chk("ar_pre_req", 32'(mem_req), 32'd1);
    chk("ar_pre_addr", 32'(mem_addr), 32'h103);
    rst_n = 1'b0;
    #1;
    chk("ar_req_now", 32'(mem_req), 32'd0);
    chk("ar_valid_now", 32'(pixel_valid), 32'd0);
    chk("ar_pix_now", 32'(pixel_out), 32'd0);
    do_reset();
    repeat (20) cycle(0, 16'h0, OUTX, OUTY, 1);
    chk("ar_idle_req_cycles", 32'(req_cycles), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
